carry_bypass_adder: RTL and testbench

- Registered WIDTH-bit carry-bypass (carry-skip) adder. Datapath module used wherever a single-cycle-latency add with carry-in and carry-out is required.
- Operands are split into BLOCK-bit ripple-carry groups. Each group has a skip multiplexer that forwards its carry-in directly to its carry-out when every bit of the group propagates.
- Result and carry-out are registered on the single clock.

---
 rtl/carry_bypass_adder.sv | 101 ++++++++++
 tb/tb_carry_bypass_adder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_bypass_adder.sv
// carry_bypass_adder
//   Registered WIDTH-bit carry-bypass (carry-skip) adder with one cycle of
//   latency. Operands are split into BLOCK-bit ripple groups. When every bit
//   of a group propagates, the group's carry-in is forwarded straight to its
//   carry-out. Functionally the result is identical to a plain ripple add.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset, overrides in_valid
//   A, B       WIDTH-bit unsigned operands
//   cin        carry-in
//   in_valid   qualifies A/B/cin this cycle
//   S          registered sum, holds while in_valid=0
//   Cout       registered carry-out, holds while in_valid=0
//   out_valid  high the cycle after an accepted in_valid
//   ovf        (only when CBA_OVERFLOW_EN is defined) registered two's-complement
//              overflow, carry into MSB xor carry out of MSB
//
// Optional feature macro: CBA_OVERFLOW_EN

module carry_bypass_adder #(
    parameter int WIDTH = 4,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             out_valid
`ifdef CBA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;        // carry into each bit
    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             carry;
    logic             grp_cin;
    logic             grp_p;

    // Walk the bits in order. At each group start the running carry is
    // captured as the group carry-in; at each group end the ripple carry is
    // replaced by that carry-in whenever the whole group propagates. The last
    // group may be narrower than BLOCK.
    always_comb begin
        p         = A ^ B;
        g         = A & B;
        c         = '0;
        carry     = cin;
        grp_cin   = cin;
        grp_p     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i % BLOCK) == 0) begin
                grp_cin = carry;
                grp_p   = 1'b1;
            end
            c[i]  = carry;
            grp_p = grp_p & p[i];
            carry = g[i] | (p[i] & carry);
            if (((i % BLOCK) == (BLOCK - 1)) || (i == (WIDTH - 1))) begin
                carry = grp_p ? grp_cin : carry;
            end
        end
        sum_next  = p ^ c;
        cout_next = carry;
    end

`ifdef CBA_OVERFLOW_EN
    logic ovf_next;
    assign ovf_next = c[WIDTH-1] ^ cout_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            S         <= '0;
            Cout      <= 1'b0;
            out_valid <= 1'b0;
`ifdef CBA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum_next;
                Cout <= cout_next;
`ifdef CBA_OVERFLOW_EN
                ovf  <= ovf_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_carry_bypass_adder.sv
module tb_carry_bypass_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-bit, single-group instance
    logic       rst4, cin4, inv4, cout4, ov4;
    logic [3:0] a4, b4, s4;
`ifdef CBA_OVERFLOW_EN
    logic       ovf4;
`endif

    carry_bypass_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
        .clk(clk), .rst(rst4), .A(a4), .B(b4), .cin(cin4), .in_valid(inv4),
        .S(s4), .Cout(cout4), .out_valid(ov4)
`ifdef CBA_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );

    // 8-bit instance with a narrow last group (3+3+2)
    logic       rst8, cin8, inv8, cout8, ov8;
    logic [7:0] a8, b8, s8;
`ifdef CBA_OVERFLOW_EN
    logic       ovf8;
`endif

    carry_bypass_adder #(.WIDTH(8), .BLOCK(3)) dut8 (
        .clk(clk), .rst(rst8), .A(a8), .B(b8), .cin(cin8), .in_valid(inv8),
        .S(s8), .Cout(cout8), .out_valid(ov8)
`ifdef CBA_OVERFLOW_EN
        , .ovf(ovf8)
`endif
    );

    typedef struct {
        logic       r;
        logic       v;
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic       ev;
        logic [3:0] es;
        logic       eco;
    } vec_t;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } exp8_t;

    vec_t  vecs [15];
    exp8_t sb [$];
    logic [7:0] held_s;
    logic       held_co;
    logic       held_ovf;

    task automatic drive8(input logic r, input logic v, input logic [7:0] a,
                          input logic [7:0] b, input logic ci);
        exp8_t      e;
        logic [8:0] sum;
        rst8 = r; inv8 = v; a8 = a; b8 = b; cin8 = ci;
        sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.s   = sum[7:0];
        e.co  = sum[8];
        e.ovf = (a[7] == b[7]) && (sum[7] != a[7]);
        if (v && !r) sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
        end
        total++;
        if (ov8 !== (v && !r)) begin
            bad++;
            $display("FAIL w8_valid a=%h b=%h got=%b want=%b", a, b, ov8, v && !r);
        end
        if (ov8 === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL w8_sb_empty got=%h/%b want=none", s8, cout8);
            end else begin
                e = sb.pop_front();
                if ({cout8, s8} !== {e.co, e.s}) begin
                    bad++;
                    $display("FAIL w8_sum a=%h b=%h ci=%b got=%b_%h want=%b_%h",
                             a, b, ci, cout8, s8, e.co, e.s);
                end
                held_s = e.s; held_co = e.co; held_ovf = e.ovf;
`ifdef CBA_OVERFLOW_EN
                total++;
                if (ovf8 !== e.ovf) begin
                    bad++;
                    $display("FAIL w8_ovf a=%h b=%h got=%b want=%b", a, b, ovf8, e.ovf);
                end
`endif
            end
        end else begin
            total++;
            if ({cout8, s8} !== {held_co, held_s}) begin
                bad++;
                $display("FAIL w8_hold got=%b_%h want=%b_%h", cout8, s8, held_co, held_s);
            end
`ifdef CBA_OVERFLOW_EN
            total++;
            if (ovf8 !== held_ovf) begin
                bad++;
                $display("FAIL w8_ovf_hold got=%b want=%b", ovf8, held_ovf);
            end
`endif
        end
    endtask

    initial begin
        logic [7:0] pat;
        //           r     v     a     b     ci    ev    es    eco
        vecs[0]  = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'hC, 4'h3, 1'b1, 1'b1, 4'h0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 4'hC, 4'h3, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'h5, 4'h3, 1'b0, 1'b1, 4'h8, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 4'h9, 4'h9, 1'b1, 1'b1, 4'h3, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h3, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 4'h7, 4'h8, 1'b0, 1'b1, 4'hF, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 4'hA, 4'h6, 1'b0, 1'b1, 4'h0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 4'h2, 4'h3, 1'b1, 1'b1, 4'h6, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 1'b1, 4'h0, 1'b1};

        rst4 = 1'b1; inv4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        rst8 = 1'b1; inv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
        @(negedge clk);

        // 4-bit table: expected outputs after each edge
        for (int i = 0; i < 15; i++) begin
            rst4 = vecs[i].r; inv4 = vecs[i].v; a4 = vecs[i].a;
            b4 = vecs[i].b;   cin4 = vecs[i].ci;
            @(posedge clk);
            #1;
            total++;
            if (ov4 !== vecs[i].ev) begin
                bad++;
                $display("FAIL w4_valid[%0d] got=%b want=%b", i, ov4, vecs[i].ev);
            end
            total++;
            if (s4 !== vecs[i].es) begin
                bad++;
                $display("FAIL w4_sum[%0d] got=%h want=%h", i, s4, vecs[i].es);
            end
            total++;
            if (cout4 !== vecs[i].eco) begin
                bad++;
                $display("FAIL w4_cout[%0d] got=%b want=%b", i, cout4, vecs[i].eco);
            end
        end
        rst4 = 1'b1; inv4 = 1'b0;

        // 8-bit: reset, then sweep every A against structured B patterns
        drive8(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        drive8(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        drive8(1'b0, 1'b1, 8'h7F, 8'h01, 1'b0);
        drive8(1'b0, 1'b1, 8'h80, 8'h80, 1'b0);
        drive8(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int a = 0; a < 256; a++) begin
            pat = a[7:0];
            drive8(1'b0, 1'b1, pat, ~pat, a[0]);
            drive8(1'b0, 1'b1, pat, 8'hFF, a[1]);
            drive8(1'b0, 1'b1, pat, pat, a[2]);
            drive8(1'b0, 1'b1, pat, 8'h01, 1'b0);
            drive8(1'b0, 1'b1, pat, 8'($urandom_range(0, 255)), a[3]);
        end
        // reset mid-stream drops the pending result
        drive8(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        drive8(1'b1, 1'b1, 8'h55, 8'h55, 1'b1);
        drive8(1'b0, 1'b1, 8'h01, 8'h02, 1'b1);
        for (int n = 0; n < 2000; n++) begin
            drive8(1'b0, ($urandom_range(0, 3) != 0),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
